dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
- Load/store initiator between the CPU memory stage and a multi-cycle data memory responder.
- Decodes load/store opcodes from Ins. Issues one request per memory instruction over a req/ack handshake and stalls the core until the access completes.
- Handles byte-lane steering, sign/zero extension, misalignment detection and a response timeout.
- Lets the board build replace the single-cycle data memory with a slower memory block without touching the core datapath.

Parameters:
- TIMEOUT_CYC, 16, cycles in REQ without MemAck before abort; 0 disables the timeout.
- AW, 30, word-address width of MemAddr.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- Ins  in  32  current memory-stage instruction; op = Ins[31:26]
- Result  in  32  effective byte address from the ALU
- Rdata2  in  32  store data (rt)
- Start  in  1  instruction valid in memory stage; held high while Stall=1
- Stall  out  1  core must hold its state
- LoadData  out  32  extended load result, valid while LoadValid=1
- LoadValid  out  1  one-cycle load completion strobe
- AdrErr  out  1  one-cycle misaligned-access strobe
- BusErr  out  1  one-cycle timeout strobe
- MemReq  out  1  request to the memory responder
- MemWe  out  1  1 = write
- MemAddr  out  AW  word address = Result[31:2]
- MemBe  out  4  byte enables, bit i = byte lane i (little-endian)
- MemWdata  out  32  lane-replicated store data
- MemAck  in  1  responder completion; meaningful only while MemReq=1
- MemRdata  in  32  read word, valid in the MemAck cycle

Behaviour:
- Reset (asynchronous, RST=1): state IDLE; MemReq, MemWe, MemBe, LoadValid, AdrErr and BusErr all 0; MemAddr, MemWdata and LoadData 0; timeout counter 0.
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW. Any other op with Start=1 causes no request and no stall.
- States: IDLE, REQ, DONE.
- IDLE -> REQ: Start=1, op is a memory op, address aligned.
  - On the transition edge, register MemReq=1, MemWe, MemAddr, MemBe and MemWdata.
  - Stall is asserted combinationally in that IDLE cycle.
- Alignment rule: halfword accesses need Result[0]=0; word accesses need Result[1:0]=0.
  - Misaligned access: no request, AdrErr pulses for 1 cycle on the next edge, stay in IDLE, Stall=0.
- REQ:
  - Stall=1. MemReq and all Mem* outputs stay stable until MemAck is sampled high.
  - MemAck=1 on a load: capture the extended data into LoadData, go to DONE.
  - MemAck=1 on a store: go to DONE.
  - Timeout: the counter increments each REQ cycle without ack. When count = TIMEOUT_CYC-1 with no ack, drop MemReq, pulse BusErr, go to IDLE. LoadData is left unchanged.
- DONE:
  - Stall=0 and MemReq=0. LoadValid=1 only for loads.
  - Core advances at the end of this cycle. Always return to IDLE; Start is not sampled in DONE, so the same instruction is never reissued.
- Minimum latency with ack in the first REQ cycle: Start at edge 0, MemReq high at cycle 1, DONE/LoadValid at cycle 2. Memory ops therefore cost 3 cycles.
- Store lanes:
  - SB: MemBe = 1<<Result[1:0]; MemWdata = {4{Rdata2[7:0]}}.
  - SH: MemBe = Result[1] ? 1100 : 0011; MemWdata = {2{Rdata2[15:0]}}.
  - SW: MemBe = 1111.
- Load extraction: pick the lane(s) by Result[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. MemBe is 1111 for all loads.
- MemAck while MemReq=0 is ignored.
- RST asserted mid-REQ drops MemReq immediately; the responder must tolerate an abandoned request.

Decomposition:
- Shared package common_param.vh:
  - Opcode constants LB=6'h20, LH=6'h21, LW=6'h23, LBU=6'h24, LHU=6'h25, SB=6'h28, SH=6'h29, SW=6'h2B (LW and SW already present; add the rest).
  - State encodings ST_IDLE, ST_REQ, ST_DONE.
- Sub-module dm_lane_align: combinational store steering (MemBe, MemWdata) plus load extraction/extension, shared by RTL and the bench reference model.

Test Plan:
- SW, Result=0x10, Rdata2=0xDEADBEEF, ack on first REQ cycle -> MemAddr=0x4, MemBe=1111, MemWe=1, Stall high for exactly 2 cycles, no LoadValid.
- LB, Result=0x13, MemRdata=0x80FF_FF7F -> MemBe=1111, LoadData=0xFFFFFF80; same access with LBU -> 0x00000080.
- SH, Result=0x22, Rdata2=0x1234ABCD -> MemBe=1100, MemWdata=0xABCDABCD; LH at 0x21 -> AdrErr pulse, MemReq never rises, Stall=0.
- LW with ack delayed 5 cycles -> MemAddr/MemBe stable throughout, Stall=1 for 6 cycles, LoadValid 1 cycle with LoadData=MemRdata.
- No ack, TIMEOUT_CYC=16 -> MemReq drops after 16 REQ cycles, BusErr 1-cycle pulse, state IDLE, LoadData unchanged.
- RST pulsed in the middle of REQ -> MemReq=0 asynchronously, all outputs at reset values; next LW after release completes normally.

Source files
------------

// File: rtl/dm_access_ctrl_pkg.sv
// dm_access_ctrl_pkg: load/store opcodes, controller states and opcode classification helpers.
package dm_access_ctrl_pkg;
  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2B;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_DONE = 2'd2} state_e;
  function automatic logic is_load(input logic [5:0] op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction
  function automatic logic is_store(input logic [5:0] op);
    return op inside {SB, SH, SW};
  endfunction
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] off);
    return (op inside {LH, LHU, SH} && off[0]) || (op inside {LW, SW} && off != 2'b00);
  endfunction
endpackage

// File: rtl/dm_access_ctrl_lane_align.sv
// dm_lane_align: store byte-lane steering and load lane extraction with sign/zero extension.
module dm_lane_align
  import dm_access_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);
  logic [7:0]  byte_l;
  logic [15:0] half_l;
  always_comb begin
    byte_l  = rd_data[{off, 3'b000} +: 8];
    half_l  = off[1] ? rd_data[31:16] : rd_data[15:0];
    be      = op == SB ? 4'b0001 << off : op == SH ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata   = op == SB ? {4{st_data[7:0]}} : op == SH ? {2{st_data[15:0]}} : st_data;
    ld_data = op == LB  ? {{24{byte_l[7]}}, byte_l} :
              op == LBU ? {24'b0, byte_l} :
              op == LH  ? {{16{half_l[15]}}, half_l} :
              op == LHU ? {16'b0, half_l} : rd_data;
  end
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: issues one req/ack memory access per load/store and stalls the core until it
// completes, flagging misaligned addresses and unanswered requests.
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int AW          = 30
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   Ins,
  input  logic [31:0]   Result,
  input  logic [31:0]   Rdata2,
  input  logic          Start,
  output logic          Stall,
  output logic [31:0]   LoadData,
  output logic          LoadValid,
  output logic          AdrErr,
  output logic          BusErr,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [3:0]    MemBe,
  output logic [31:0]   MemWdata,
  input  logic          MemAck,
  input  logic [31:0]   MemRdata
);
  localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  state_e        state_q, state_d;
  logic [5:0]    op, op_q, op_d, la_op;
  logic [1:0]    off_q, off_d, la_off;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d, la_be;
  logic [31:0]   mem_wdata_q, mem_wdata_d, load_data_q, load_data_d, la_wdata, la_ldata;
  logic          load_valid_q, load_valid_d, adr_err_q, adr_err_d, bus_err_q, bus_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_mem, go, timeout;
  assign op = Ins[31:26];
  // One steering instance: IDLE uses the incoming instruction, REQ the captured one.
  dm_lane_align u_lane (
    .op(la_op), .off(la_off), .st_data(Rdata2), .rd_data(MemRdata),
    .be(la_be), .wdata(la_wdata), .ld_data(la_ldata)
  );
  always_comb begin
    is_mem       = is_load(op) || is_store(op);
    go           = state_q == ST_IDLE && Start && is_mem && !misaligned(op, Result[1:0]);
    timeout      = TIMEOUT_CYC != 0 && state_q == ST_REQ && !MemAck && cnt_q == CW'(TIMEOUT_CYC - 1);
    la_op        = state_q == ST_IDLE ? op : op_q;
    la_off       = state_q == ST_IDLE ? Result[1:0] : off_q;
    state_d      = state_q;
    op_d         = op_q;
    off_d        = off_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    adr_err_d    = 1'b0;
    bus_err_d    = 1'b0;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        adr_err_d = Start && is_mem && misaligned(op, Result[1:0]);
        if (go) begin
          state_d     = ST_REQ;
          op_d        = op;
          off_d       = Result[1:0];
          mem_req_d   = 1'b1;
          mem_we_d    = is_store(op);
          mem_addr_d  = AW'(Result[31:2]);
          mem_be_d    = la_be;
          mem_wdata_d = la_wdata;
          cnt_d       = '0;
        end
      end
      ST_REQ: begin
        if (MemAck || timeout) begin
          state_d      = MemAck ? ST_DONE : ST_IDLE;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_be_d     = 4'b0000;
          load_valid_d = MemAck && is_load(op_q);
          load_data_d  = MemAck && is_load(op_q) ? la_ldata : load_data_q;
          bus_err_d    = !MemAck;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      off_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      adr_err_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      off_q        <= off_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      adr_err_q    <= adr_err_d;
      bus_err_q    <= bus_err_d;
      cnt_q        <= cnt_d;
    end
  end
  assign Stall     = go || state_q == ST_REQ;
  assign LoadData  = load_data_q;
  assign LoadValid = load_valid_q;
  assign AdrErr    = adr_err_q;
  assign BusErr    = bus_err_q;
  assign MemReq    = mem_req_q;
  assign MemWe     = mem_we_q;
  assign MemAddr   = mem_addr_q;
  assign MemBe     = mem_be_q;
  assign MemWdata  = mem_wdata_q;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: per-transaction timeline model of the access controller checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_dm_access_ctrl;
  localparam int TO = 16;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                         OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
  logic        CLK = 1'b0, RST = 1'b1;
  logic [31:0] Ins = '0, Result = '0, Rdata2 = '0, MemRdata = '0;
  logic        Start = 1'b0, MemAck = 1'b0;
  logic        Stall, LoadValid, AdrErr, BusErr, MemReq, MemWe;
  logic [31:0] LoadData, MemWdata;
  logic [29:0] MemAddr;
  logic [3:0]  MemBe;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  logic e_stall = 0, e_req = 0, e_we = 0, e_lv = 0, e_adr = 0, e_bus = 0, e_st = 0;
  logic [31:0] e_addr = '0, e_wd = '0, m_load = '0;
  logic [3:0]  e_be = '0;
  int n_stall, n_req, n_lv, n_adr, n_bus;
  logic [31:0] cap_addr, cap_wd;
  logic [3:0]  cap_be;
  logic        cap_we;

  dm_access_ctrl #(.TIMEOUT_CYC(TO), .AW(30)) dut (
    .CLK(CLK), .RST(RST), .Ins(Ins), .Result(Result), .Rdata2(Rdata2), .Start(Start),
    .Stall(Stall), .LoadData(LoadData), .LoadValid(LoadValid), .AdrErr(AdrErr), .BusErr(BusErr),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemBe(MemBe), .MemWdata(MemWdata),
    .MemAck(MemAck), .MemRdata(MemRdata)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_is_load(input logic [5:0] op);
    return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
  endfunction
  function automatic bit m_is_mem(input logic [5:0] op);
    return m_is_load(op) || op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction
  function automatic int m_size(input logic [5:0] op);
    return (op == OP_LW || op == OP_SW) ? 4 : (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
  endfunction
  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] a);
    int k = int'(a % 4);
    if (op == OP_SB) return 4'(1 << k);
    if (op == OP_SH) return k >= 2 ? 4'hC : 4'h3;
    return 4'hF;
  endfunction
  function automatic logic [31:0] m_wd(input logic [5:0] op, input logic [31:0] d);
    if (op == OP_SB) return d[7:0] * 32'h01010101;
    if (op == OP_SH) return d[15:0] * 32'h00010001;
    return d;
  endfunction
  function automatic logic [31:0] m_ld(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] w = rd >> (8 * (a % 4));
    logic [7:0]  b = w[7:0];
    logic [15:0] h = w[15:0];
    if (op == OP_LB)  return 32'($signed(b));
    if (op == OP_LBU) return {24'b0, b};
    if (op == OP_LH)  return 32'($signed(h));
    if (op == OP_LHU) return {16'b0, h};
    return rd;
  endfunction

  always @(negedge CLK) if (chk_en) begin
    chk("Stall", 32'(Stall), 32'(e_stall));
    chk("MemReq", 32'(MemReq), 32'(e_req));
    chk("LoadValid", 32'(LoadValid), 32'(e_lv));
    chk("AdrErr", 32'(AdrErr), 32'(e_adr));
    chk("BusErr", 32'(BusErr), 32'(e_bus));
    chk("LoadData", LoadData, m_load);
    if (e_req) begin
      chk("MemWe", 32'(MemWe), 32'(e_we));
      chk("MemAddr", 32'(MemAddr), e_addr);
      chk("MemBe", 32'(MemBe), 32'(e_be));
      if (e_st) chk("MemWdata", MemWdata, e_wd);
    end
    if (Stall) n_stall++;
    if (LoadValid) n_lv++;
    if (AdrErr) n_adr++;
    if (BusErr) n_bus++;
    if (MemReq) begin
      n_req++;
      cap_addr = 32'(MemAddr);
      cap_be = MemBe;
      cap_wd = MemWdata;
      cap_we = MemWe;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    n_stall = 0; n_req = 0; n_lv = 0; n_adr = 0; n_bus = 0;
  endtask

  // ack_at: REQ cycle (1-based) on which MemAck is raised; 0 = never acknowledge.
  task automatic run_op(input logic [5:0] op, input logic [31:0] res, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_at);
    bit mem = m_is_mem(op);
    bit bad = mem && (res % m_size(op)) != 0;
    bit acked = 0;
    clr();
    step();
    Ins = {op, 26'h15A5A5}; Result = res; Rdata2 = wd; MemRdata = rd; Start = 1; MemAck = 0;
    e_stall = mem && !bad; e_req = 0; e_lv = 0; e_adr = 0; e_bus = 0;
    if (!mem || bad) begin
      step();
      Start = 0; e_stall = 0; e_adr = bad;
      step();
      e_adr = 0;
      return;
    end
    for (int r = 1; r <= TO; r++) begin
      step();
      e_stall = 1; e_req = 1; e_we = !m_is_load(op); e_st = !m_is_load(op);
      e_addr = res >> 2; e_be = m_be(op, res); e_wd = m_wd(op, wd);
      MemAck = (r == ack_at);
      acked = MemAck;
      if (acked) break;
    end
    step();
    MemAck = 0; e_stall = 0; e_req = 0;
    if (acked) begin
      e_lv = m_is_load(op);
      if (m_is_load(op)) m_load = m_ld(op, res, rd);
    end else begin
      e_bus = 1; Start = 0;
    end
    step();
    Start = 0; e_lv = 0; e_bus = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_MemReq", 32'(MemReq), 0);
    chk("rst_MemWe", 32'(MemWe), 0);
    chk("rst_MemBe", 32'(MemBe), 0);
    chk("rst_MemAddr", 32'(MemAddr), 0);
    chk("rst_MemWdata", MemWdata, 0);
    chk("rst_LoadData", LoadData, 0);
    chk("rst_flags", {29'b0, LoadValid, AdrErr, BusErr}, 0);
    step(); step();
    RST = 0; chk_en = 1;

    run_op(OP_SW, 32'h10, 32'hDEADBEEF, 32'h0, 1);
    chk("sw_addr", cap_addr, 32'h4);
    chk("sw_be", 32'(cap_be), 32'hF);
    chk("sw_we", 32'(cap_we), 1);
    chk("sw_wd", cap_wd, 32'hDEADBEEF);
    chk("sw_stall_cycles", n_stall, 2);
    chk("sw_no_lv", n_lv, 0);

    run_op(OP_LB, 32'h13, 32'h0, 32'h80FFFF7F, 1);
    chk("lb_be", 32'(cap_be), 32'hF);
    chk("lb_data", LoadData, 32'hFFFFFF80);
    chk("lb_lv", n_lv, 1);
    run_op(OP_LBU, 32'h13, 32'h0, 32'h80FFFF7F, 1);
    chk("lbu_data", LoadData, 32'h00000080);

    run_op(OP_SH, 32'h22, 32'h1234ABCD, 32'h0, 1);
    chk("sh_be", 32'(cap_be), 32'hC);
    chk("sh_wd", cap_wd, 32'hABCDABCD);
    run_op(OP_LH, 32'h21, 32'h0, 32'h0, 1);
    chk("lh_mis_adr", n_adr, 1);
    chk("lh_mis_req", n_req, 0);
    chk("lh_mis_stall", n_stall, 0);

    run_op(OP_LW, 32'h40, 32'h0, 32'hCAFEF00D, 5);
    chk("lw_slow_stall", n_stall, 6);
    chk("lw_slow_req", n_req, 5);
    chk("lw_slow_lv", n_lv, 1);
    chk("lw_slow_data", LoadData, 32'hCAFEF00D);

    run_op(OP_LH, 32'h2, 32'h0, 32'h80010000, 2);
    chk("lh_hi", LoadData, 32'hFFFF8001);
    run_op(OP_LHU, 32'h2, 32'h0, 32'h80010000, 1);
    chk("lhu_hi", LoadData, 32'h00008001);
    run_op(OP_SB, 32'h1, 32'h000000A5, 32'h0, 3);
    chk("sb_be", 32'(cap_be), 32'h2);
    chk("sb_wd", cap_wd, 32'hA5A5A5A5);
    run_op(OP_SW, 32'h6, 32'h0, 32'h0, 1);
    chk("sw_mis_adr", n_adr, 1);

    clr();
    step();
    Start = 1; Ins = 32'h0; MemAck = 1;
    step();
    Start = 0; MemAck = 0;
    step();
    chk("nonmem_req", n_req, 0);
    chk("nonmem_stall", n_stall, 0);

    run_op(OP_LW, 32'h80, 32'h0, 32'h12345678, 0);
    chk("to_req_cycles", n_req, TO);
    chk("to_buserr", n_bus, 1);
    chk("to_stall", n_stall, TO + 1);
    chk("to_loaddata", LoadData, 32'h00008001);
    chk("to_lv", n_lv, 0);

    step();
    Start = 1; Ins = {OP_LW, 26'h0}; Result = 32'h100; e_stall = 1; e_req = 0;
    step();
    e_req = 1; e_we = 0; e_st = 0; e_addr = 32'h40; e_be = 4'hF;
    step();
    #2;
    chk_en = 0; RST = 1; Start = 0;
    #1;
    chk("midrst_MemReq", 32'(MemReq), 0);
    chk("midrst_MemAddr", 32'(MemAddr), 0);
    chk("midrst_MemBe", 32'(MemBe), 0);
    chk("midrst_LoadData", LoadData, 0);
    chk("midrst_Stall", 32'(Stall), 0);
    step(); step();
    RST = 0; m_load = 0; e_stall = 0; e_req = 0; chk_en = 1;
    run_op(OP_LW, 32'h100, 32'h0, 32'h0BADF00D, 2);
    chk("post_rst_lw", LoadData, 32'h0BADF00D);
    step();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
